// File: rtl/tone_square_gen.sv
// Square-wave tone generator: glitch-free divider reload at half-period boundaries, click-free stop.
// Optional amplitude fade-in/fade-out paced by sample_tick when TONE_FADE_EN is defined.
module tone_square_gen #(
    parameter int                   AMP_WIDTH = 16,
    parameter logic [AMP_WIDTH-1:0] AMPLITUDE = 16'h2000,
    parameter logic [31:0]          MIN_DIV   = 32'd2,
    parameter logic [AMP_WIDTH-1:0] FADE_STEP = 16'h0010
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        enable,
    input  logic [31:0]                 Clk_div_num,
    input  logic [15:0]                 tone_name,
    input  logic                        sample_tick,
    output logic                        tone_out,
    output logic signed [AMP_WIDTH-1:0] sample,
    output logic [31:0]                 div_active,
    output logic [15:0]                 tone_name_latched,
    output logic                        tone_change,
    output logic                        running
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]                  state_q, state_d;
    logic [31:0]                 cnt_q, cnt_d;
    logic [31:0]                 div_q, div_d;
    logic [15:0]                 name_q, name_d;
    logic                        tone_q, tone_d;
    logic                        chg_q, chg_d;
    logic signed [AMP_WIDTH-1:0] sample_q, sample_d;
    logic [AMP_WIDTH-1:0]        amp_cur;
    logic signed [AMP_WIDTH-1:0] amp_s;
    logic [31:0]                 div_in;
    logic                        bnd;
    logic                        end_run;
    logic                        end_stop;

    assign div_in = (Clk_div_num < MIN_DIV) ? MIN_DIV : Clk_div_num;
    assign bnd    = (state_q != ST_IDLE) && (cnt_q == div_q - 32'd1);
    assign amp_s  = $signed(amp_cur);

`ifdef TONE_FADE_EN
    logic [AMP_WIDTH-1:0] amp_q, amp_d;

    function automatic logic [AMP_WIDTH-1:0] fade_up(input logic [AMP_WIDTH-1:0] a);
        return (AMPLITUDE - a < FADE_STEP) ? AMPLITUDE : a + FADE_STEP;
    endfunction

    function automatic logic [AMP_WIDTH-1:0] fade_dn(input logic [AMP_WIDTH-1:0] a);
        return (a < FADE_STEP) ? '0 : a - FADE_STEP;
    endfunction

    // With fading, the tone ends only once the amplitude has fully decayed, at any phase.
    assign amp_cur  = amp_q;
    assign end_run  = 1'b0;
    assign end_stop = (amp_q == '0);

    always_comb begin
        amp_d = amp_q;
        case (state_q)
            ST_IDLE: if (enable) amp_d = '0;
            ST_RUN:  if (sample_tick) amp_d = fade_up(amp_q);
            ST_STOP: if (sample_tick) amp_d = fade_dn(amp_q);
            default: amp_d = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            amp_q <= '0;
        end else begin
            amp_q <= amp_d;
        end
    end
`else
    logic unused_fade;

    // Without fading, stopping waits for the end of a high half so the wave always ends low.
    assign amp_cur     = AMPLITUDE;
    assign end_run     = bnd && tone_q;
    assign end_stop    = bnd && tone_q;
    assign unused_fade = sample_tick ^ (^FADE_STEP);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tone_d  = tone_q;
        div_d   = div_q;
        name_d  = name_q;
        chg_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                    div_d   = div_in;
                    name_d  = tone_name;
                    chg_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) state_d = end_run ? ST_IDLE : ST_STOP;
            end
            ST_STOP: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (end_stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The divider and name are only picked up at a half-period boundary, keeping the wave glitch-free.
        if (state_q != ST_IDLE) begin
            if (bnd) begin
                tone_d = ~tone_q;
                cnt_d  = '0;
                div_d  = div_in;
                name_d = tone_name;
                chg_d  = (div_in != div_q);
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        if (state_d == ST_IDLE) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end

        sample_d = ((state_q == ST_IDLE) || (state_d == ST_IDLE)) ? '0 : (tone_q ? amp_s : -amp_s);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            tone_q   <= 1'b0;
            div_q    <= '0;
            name_q   <= '0;
            chg_q    <= 1'b0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tone_q   <= tone_d;
            div_q    <= div_d;
            name_q   <= name_d;
            chg_q    <= chg_d;
            sample_q <= sample_d;
        end
    end

    assign tone_out          = tone_q;
    assign sample            = sample_q;
    assign div_active        = div_q;
    assign tone_name_latched = name_q;
    assign tone_change       = chg_q;
    assign running           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tone_square_gen.sv
// Self-checking bench for tone_square_gen: vector table, directed corner sequences, randomized run vs reference model.
module tb_tone_square_gen;
    localparam logic [15:0] AMP  = 16'h2000;
    localparam logic [15:0] STEP = 16'h1000;
    localparam logic [31:0] MIN  = 32'd2;
    localparam logic [15:0] SP   = 16'h2000;
    localparam logic [15:0] SN   = 16'hE000;
    localparam logic [15:0] NA4  = 16'h4134;
    localparam logic [15:0] NB5  = 16'h4235;

    logic               Clk = 1'b0;
    logic               rst_n, en, tick_in;
    logic [31:0]        div_in;
    logic [15:0]        name_in;
    logic               tone_out, tone_change, running;
    logic signed [15:0] sample;
    logic [31:0]        div_active;
    logic [15:0]        tone_name_latched;

    int checks = 0;
    int errors = 0;
    bit chk_model = 1'b0;

    // Reference model state: playing/stopping flags, position within the half period, outputs.
    logic        m_on, m_stop, m_tone, m_chg;
    logic [31:0] m_cnt, m_div;
    logic [15:0] m_name, m_amp, m_smp;

    tone_square_gen #(
        .AMP_WIDTH(16),
        .AMPLITUDE(AMP),
        .MIN_DIV(MIN),
        .FADE_STEP(STEP)
    ) dut (
        .Clk(Clk),
        .Reset_n(rst_n),
        .enable(en),
        .Clk_div_num(div_in),
        .tone_name(name_in),
        .sample_tick(tick_in),
        .tone_out(tone_out),
        .sample(sample),
        .div_active(div_active),
        .tone_name_latched(tone_name_latched),
        .tone_change(tone_change),
        .running(running)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", what, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] amp_level();
`ifdef TONE_FADE_EN
        return m_amp;
`else
        return AMP;
`endif
    endfunction

    task automatic model_step();
        logic [31:0] din;
        logic        at_bnd, finish, was_tone;
        logic [15:0] was_amp;
        if (!rst_n) begin
            m_on = 0; m_stop = 0; m_tone = 0; m_chg = 0;
            m_cnt = 0; m_div = 0; m_name = 0; m_amp = 0; m_smp = 0;
            return;
        end
        din   = (div_in < MIN) ? MIN : div_in;
        m_chg = 0;
        if (!m_on) begin
            m_smp = 0;
            if (en) begin
                m_on = 1; m_stop = 0; m_div = din; m_name = name_in;
                m_chg = 1; m_cnt = 0; m_tone = 0; m_amp = 0;
            end
            return;
        end
        was_tone = m_tone;
        was_amp  = amp_level();
        at_bnd   = (m_cnt == m_div - 1);
`ifdef TONE_FADE_EN
        finish = m_stop && !en && (m_amp == 0);
        if (tick_in) begin
            if (m_stop) m_amp = (m_amp < STEP) ? 16'h0 : m_amp - STEP;
            else        m_amp = (AMP - m_amp < STEP) ? AMP : m_amp + STEP;
        end
`else
        finish = !en && at_bnd && m_tone;
`endif
        if (at_bnd) begin
            m_tone = !m_tone;
            m_cnt  = 0;
            m_chg  = (din != m_div);
            m_div  = din;
            m_name = name_in;
        end else begin
            m_cnt = m_cnt + 1;
        end
        m_stop = !en;
        if (finish) begin
            m_on = 0; m_stop = 0; m_tone = 0; m_cnt = 0; m_smp = 0;
        end else begin
            m_smp = was_tone ? was_amp : -was_amp;
        end
    endtask

    task automatic compare_model();
        check("running", {31'b0, running}, {31'b0, m_on});
        check("tone_out", {31'b0, tone_out}, {31'b0, m_tone});
        check("tone_change", {31'b0, tone_change}, {31'b0, m_chg});
        check("div_active", div_active, m_div);
        check("tone_name_latched", {16'h0, tone_name_latched}, {16'h0, m_name});
        check("sample", {16'h0, sample}, {16'h0, m_smp});
    endtask

    task automatic step_clk();
        model_step();
        @(posedge Clk);
        #1;
        if (chk_model) compare_model();
    endtask

    task automatic measure_half(output int n);
        logic t0;
        t0 = tone_out;
        n  = 0;
        while (tone_out === t0 && n < 100) begin
            step_clk();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL half_period_timeout: tone_out stuck at %0b, required a toggle within 100 cycles", t0);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [31:0] div;
        logic [15:0] name;
        logic        e_tone;
        logic        e_run;
        logic        e_chg;
        logic [31:0] e_div;
        logic [15:0] e_name;
        logic [15:0] e_smp;
    } vec_t;

    vec_t        vt [17];
    logic        tone_pat [14] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    logic [15:0] smp_pat  [14] = '{16'h0, SN, SN, SN, SN, SP, SP, SP, SP, SN, SN, SN, SN, SP};

    initial begin
        int n;
        int mag;

        for (int i = 0; i < 3; i++) vt[i] = '{1'b0, 1'b1, 32'd4, NA4, 1'b0, 1'b0, 1'b0, 32'd0, 16'h0, 16'h0};
        for (int i = 0; i < 14; i++)
            vt[i+3] = '{1'b1, 1'b1, 32'd4, NA4, tone_pat[i], 1'b1, (i == 0), 32'd4, NA4, smp_pat[i]};

        m_on = 0; m_stop = 0; m_tone = 0; m_chg = 0;
        m_cnt = 0; m_div = 0; m_name = 0; m_amp = 0; m_smp = 0;
        rst_n = 0; en = 0; tick_in = 0; div_in = 32'd4; name_in = NA4;

        // Reset held with enable high, then a basic div-4 tone.
        for (int i = 0; i < 17; i++) begin
            rst_n  = vt[i].rst_n;
            en     = vt[i].en;
            div_in = vt[i].div;
            name_in = vt[i].name;
            step_clk();
            check($sformatf("vec%0d_running", i), {31'b0, running}, {31'b0, vt[i].e_run});
            check($sformatf("vec%0d_tone", i), {31'b0, tone_out}, {31'b0, vt[i].e_tone});
            check($sformatf("vec%0d_change", i), {31'b0, tone_change}, {31'b0, vt[i].e_chg});
            check($sformatf("vec%0d_div", i), div_active, vt[i].e_div);
            check($sformatf("vec%0d_name", i), {16'h0, tone_name_latched}, {16'h0, vt[i].e_name});
            check($sformatf("vec%0d_sample", i), {16'h0, sample}, {16'h0, vt[i].e_smp});
        end
        chk_model = 1'b1;

        // Divider change at cnt=1 of a high half.
        div_in = 32'd6; name_in = NB5;
        measure_half(n);
        check("midchg_old_half", n, 3);
        check("midchg_pulse", {31'b0, tone_change}, 1);
        check("midchg_div", div_active, 6);
        check("midchg_name", {16'h0, tone_name_latched}, {16'h0, NB5});
        step_clk();
        check("midchg_pulse_width", {31'b0, tone_change}, 0);
        measure_half(n);
        check("midchg_new_half", n, 5);

        // Clamp of 0 and 1 up to the minimum divider.
        div_in = 32'd0;
        measure_half(n);
        check("clamp_pending_half", n, 6);
        check("clamp_div0", div_active, 2);
        div_in = 32'd1;
        measure_half(n);
        check("clamp_half0", n, 2);
        measure_half(n);
        check("clamp_half1", n, 2);
        check("clamp_div1", div_active, 2);

        // Stop requested just after tone_out fell.
        en = 0;
        measure_half(n);
        check("stop_low_half", n, 2);
        check("stop_still_running", {31'b0, running}, 1);
        measure_half(n);
        check("stop_high_half", n, 2);
        check("stop_idle", {31'b0, running}, 0);
        check("stop_sample_zero", {16'h0, sample}, 0);
        step_clk();
        check("idle_sample_zero", {16'h0, sample}, 0);

        // Restart, then a brief enable drop that must not disturb the phase.
        div_in = 32'd4; name_in = NA4; en = 1;
        step_clk();
        check("restart_running", {31'b0, running}, 1);
        check("restart_change", {31'b0, tone_change}, 1);
        measure_half(n);
        check("restart_first_half", n, 4);
        en = 0;
        step_clk();
        check("pause_running", {31'b0, running}, 1);
        en = 1;
        step_clk();
        check("resume_no_change", {31'b0, tone_change}, 0);
        measure_half(n);
        check("resume_phase", n, 2);
        measure_half(n);
        check("resume_next_half", n, 4);

        // Reset while playing.
        rst_n = 0;
        step_clk();
        check("midreset_running", {31'b0, running}, 0);
        check("midreset_tone", {31'b0, tone_out}, 0);
        check("midreset_div", div_active, 0);
        check("midreset_sample", {16'h0, sample}, 0);
        rst_n = 1; en = 0;
        step_clk();

`ifdef TONE_FADE_EN
        en = 1; div_in = 32'd4;
        for (int i = 0; i < 24; i++) begin
            tick_in = (i % 4 == 0);
            step_clk();
        end
        tick_in = 0;
        mag = (sample < 0) ? -int'(sample) : int'(sample);
        check("fade_full_magnitude", mag, 32'h2000);
        en = 0;
        for (int i = 0; i < 100 && running; i++) begin
            tick_in = (i % 4 == 0);
            step_clk();
        end
        tick_in = 0;
        check("fade_reaches_idle", {31'b0, running}, 0);
`else
        mag = 0;
`endif

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 9) == 0) begin
                div_in  = $urandom_range(0, 9);
                name_in = 16'($urandom);
            end
            tick_in = ($urandom_range(0, 3) == 0);
            rst_n   = ($urandom_range(0, 299) != 0);
            step_clk();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_square_gen.md
# tone_square_gen

Programmable square-wave tone generator that sits directly downstream of the tone selector. It consumes the selector's 32-bit half-period divider and 16-bit ASCII tone name and produces a 1-bit tone output and a signed audio sample for the codec path. Divider changes are applied only at half-period boundaries, so the waveform never glitches. Start and stop are click-free. The latched tone name is exported for the display path.

## Interface
Parameters:
- AMP_WIDTH, 16, width of the signed sample output
- AMPLITUDE, 16'h2000, full-scale sample magnitude (positive value)
- MIN_DIV, 32'd2, smallest legal half-period; smaller inputs are clamped up to this value
- FADE_STEP, 16'h0010, per-tick amplitude step (used only with TONE_FADE_EN)

Ports:
- Clk  in  1  system clock. One clock domain, all logic on its rising edge.
- Reset_n  in  1  reset; synchronous, active-low
- enable  in  1  level request to play the tone
- Clk_div_num  in  32  half-period in Clk cycles, from the selector
- tone_name  in  16  two ASCII characters, from the selector
- sample_tick  in  1  one-cycle audio sample strobe; drives fade updates
- tone_out  out  1  square wave
- sample  out  AMP_WIDTH  signed sample: +amp when tone_out=1, -amp when tone_out=0, 0 in IDLE
- div_active  out  32  half-period currently in use
- tone_name_latched  out  16  name associated with div_active
- tone_change  out  1  one-cycle pulse when div_active is (re)loaded with a new value
- running  out  1  high in any state other than IDLE

## Operation
- div_in = max(Clk_div_num, MIN_DIV). Unsigned 32-bit compare.
- Half-period counter cnt: 32 bits.
- A boundary is a cycle in a non-IDLE state where cnt == div_active-1. At the next edge:
  - tone_out toggles and cnt clears to 0.
  - div_active loads div_in and tone_name_latched loads tone_name.
  - tone_change pulses if the new div_in differs from the old div_active.
- On any non-boundary cycle in a non-IDLE state, cnt increments.
- States:
  - IDLE: cnt=0, tone_out=0, sample=0.
  - RUN
  - STOP: counting continues.
- Transitions:
  - IDLE→RUN when enable=1. On entry: load div_active and tone_name_latched, set cnt=0 and tone_out=0, pulse tone_change unconditionally.
  - RUN→STOP when enable=0.
  - STOP→RUN when enable=1. No reload and no tone_change pulse.
  - STOP→IDLE (without fade) at a boundary where tone_out=1, so the waveform always ends low. If enable=0 is seen at the same boundary while in RUN with tone_out=1, go directly RUN→IDLE.
- sample is registered from the previous cycle's tone_out and amp: sample = tone_out ? +amp : -amp, where amp = AMPLITUDE without fade. sample is forced to 0 in IDLE.
- Reset mid-operation: IDLE at the next edge, all outputs cleared.

## Timing
- Reset values: tone_out=0, sample=0, div_active=0, tone_name_latched=0, tone_change=0, running=0, cnt=0, state IDLE.
- enable sampled high at cycle t (in IDLE):
  - running, div_active, tone_name_latched and tone_change valid at t+1.
  - tone_out rises at t+1+div, falls at t+1+2·div. Period is 2·div cycles.
- sample lags tone_out by exactly 1 cycle.
- A Clk_div_num change mid half-period takes effect at the next boundary. The current half-period keeps its old length.
- Clk_div_num and tone_name are sampled only at boundary and IDLE→RUN edges. Between those edges they are don't-care.

## Configuration
- Macro TONE_FADE_EN.
- Undefined: amp is the constant AMPLITUDE, and STOP ends on the boundary rule above.
- Defined:
  - Amplitude register amp resets to 0 and is set to 0 on IDLE→RUN.
  - In RUN, each sample_tick adds FADE_STEP, saturating at AMPLITUDE.
  - In STOP, each sample_tick subtracts FADE_STEP, saturating at 0.
  - STOP→IDLE occurs the edge after amp reaches 0, regardless of phase; the boundary rule is not used.
  - STOP→RUN resumes ramping up from the current amp.
  - sample_tick is ignored in IDLE.

## Test plan
- Reset: Reset_n=0 for 3 cycles with enable=1 and Clk_div_num=4 → all outputs 0 and running=0 throughout; normal start begins the cycle after Reset_n=1.
- Basic tone: Clk_div_num=4, enable high at cycle 0 → running=1, div_active=4 and tone_change=1 at cycle 1; tone_out rises at 5, falls at 9, rises at 13; sample alternates ±0x2000, one cycle behind tone_out.
- Mid-period change: while running at div 4, switch Clk_div_num to 6 at cnt=1 → current half-period stays 4 cycles; then 6-cycle half-periods; tone_change high for exactly one cycle at that boundary; tone_name_latched updates on the same edge.
- Clamp: Clk_div_num=0, then 1 → div_active=2 and tone_out period 4 cycles.
- Stop/resume: drop enable while tone_out=0 → tone_out completes its high half, returns to 0, then IDLE (running=0, sample=0). A second run: re-raise enable during STOP → stays in RUN with no tone_change and no phase disturbance.
- Fade (TONE_FADE_EN, FADE_STEP=0x1000, AMPLITUDE=0x2000, sample_tick every 4 cycles) → amp steps 0→0x1000→0x2000 and holds; after enable drop, 0x2000→0x1000→0, IDLE on the edge after reaching 0.
